// File: rtl/ddr_clk_pkg.sv
// ============================================================================
// Module      : ddr_clk_pkg
// Description : Shared defaults and counter-width helper for the DDR clock
//               generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr_clk_pkg;

    localparam int DEF_WR_HALF_PERIOD = 1;
    localparam int DEF_LOCK_CYCLES    = 16;

    // Width able to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_clk_diff_out.sv
// ============================================================================
// Module      : ddr_clk_diff_out
// Description : Complementary flop pair driving the off-chip memory clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_clk_diff_out (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic p,
    output logic n
);

    logic r_p_q;
    logic r_n_q;
    logic w_p_d;
    logic w_n_d;

    always_comb begin
        w_p_d = d;
        w_n_d = ~d;
    end

    // Two independent registers so both legs launch from the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p_q <= 1'b0;
            r_n_q <= 1'b1;
        end else begin
            r_p_q <= w_p_d;
            r_n_q <= w_n_d;
        end
    end

    assign p = r_p_q;
    assign n = r_n_q;

endmodule

`default_nettype wire

// File: rtl/ddr_clk_gen.sv
// ============================================================================
// Module      : ddr_clk_gen
// Description : Register-based WR/DDR clock divider with differential output
//               and a lock indicator, all on the reference clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_clk_gen
    import ddr_clk_pkg::*;
#(
    parameter int WR_HALF_PERIOD = DEF_WR_HALF_PERIOD,
    parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES
) (
    input  logic SYS_CLK_100M,
    input  logic RESET_N,
    output logic WR_CLK_333M,
    output logic DDR_CLK_166M,
    output logic CLK_P,
    output logic CLK_N,
    output logic LOCKED
);

    localparam int c_hc_w = cnt_width(WR_HALF_PERIOD);
    localparam int c_lc_w = cnt_width(LOCK_CYCLES);
    localparam logic [c_hc_w-1:0] c_hc_last = c_hc_w'(WR_HALF_PERIOD - 1);
    localparam logic [c_lc_w-1:0] c_lc_max  = c_lc_w'(LOCK_CYCLES);

    generate
        if (WR_HALF_PERIOD < 1) begin : g_bad_wr_half_period
            $error("ddr_clk_gen: WR_HALF_PERIOD must be >= 1");
        end
        if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
            $error("ddr_clk_gen: LOCK_CYCLES must be >= 1");
        end
    endgenerate

    logic [c_hc_w-1:0] r_hc_q;
    logic [c_hc_w-1:0] w_hc_d;
    logic [c_lc_w-1:0] r_lc_q;
    logic [c_lc_w-1:0] w_lc_d;
    logic              r_wr_q;
    logic              w_wr_d;
    logic              r_ddr_q;
    logic              w_ddr_d;
    logic              r_locked_q;
    logic              w_locked_d;
    logic              w_hc_wrap;

    always_comb begin
        w_hc_wrap  = (r_hc_q == c_hc_last);
        w_hc_d     = w_hc_wrap ? '0 : r_hc_q + 1'b1;
        w_wr_d     = r_wr_q ^ w_hc_wrap;
        // DDR advances only when WR is about to rise, keeping it WR/2 in phase.
        w_ddr_d    = r_ddr_q ^ (w_hc_wrap & ~r_wr_q);
        w_lc_d     = (r_lc_q == c_lc_max) ? r_lc_q : r_lc_q + 1'b1;
        w_locked_d = (w_lc_d == c_lc_max);
    end

    always_ff @(posedge SYS_CLK_100M) begin
        if (!RESET_N) begin
            r_hc_q     <= '0;
            r_lc_q     <= '0;
            r_wr_q     <= 1'b0;
            r_ddr_q    <= 1'b0;
            r_locked_q <= 1'b0;
        end else begin
            r_hc_q     <= w_hc_d;
            r_lc_q     <= w_lc_d;
            r_wr_q     <= w_wr_d;
            r_ddr_q    <= w_ddr_d;
            r_locked_q <= w_locked_d;
        end
    end

    ddr_clk_diff_out u_diff_out (
        .clk   (SYS_CLK_100M),
        .rst_n (RESET_N),
        .d     (w_ddr_d),
        .p     (CLK_P),
        .n     (CLK_N)
    );

    assign WR_CLK_333M  = r_wr_q;
    assign DDR_CLK_166M = r_ddr_q;
    assign LOCKED       = r_locked_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr_clk_gen.sv
// ============================================================================
// Module      : tb_ddr_clk_gen
// Description : Scoreboard bench for ddr_clk_gen, default and WR_HALF_PERIOD=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr_clk_gen;

    localparam int c_h0 = 1;
    localparam int c_l0 = 16;
    localparam int c_h1 = 3;
    localparam int c_l1 = 5;

    logic clk;
    logic rst_n;

    logic wr0, ddr0, p0, n0, lk0;
    logic wr1, ddr1, p1, n1, lk1;

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;

    typedef struct packed {
        logic wr0;
        logic ddr0;
        logic lk0;
        logic wr1;
        logic ddr1;
        logic lk1;
    } exp_t;

    exp_t exp_q[$];

    ddr_clk_gen u_dut0 (
        .SYS_CLK_100M (clk),
        .RESET_N      (rst_n),
        .WR_CLK_333M  (wr0),
        .DDR_CLK_166M (ddr0),
        .CLK_P        (p0),
        .CLK_N        (n0),
        .LOCKED       (lk0)
    );

    ddr_clk_gen #(
        .WR_HALF_PERIOD (c_h1),
        .LOCK_CYCLES    (c_l1)
    ) u_dut1 (
        .SYS_CLK_100M (clk),
        .RESET_N      (rst_n),
        .WR_CLK_333M  (wr1),
        .DDR_CLK_166M (ddr1),
        .CLK_P        (p1),
        .CLK_N        (n1),
        .LOCKED       (lk1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k = edges sampled with reset released since the last reset edge.
    function automatic exp_t model(input int k);
        exp_t e;
        int   t0;
        int   t1;
        t0     = k / c_h0;
        t1     = k / c_h1;
        e.wr0  = 1'(t0 % 2);
        e.ddr0 = 1'(((t0 + 1) / 2) % 2);
        e.lk0  = (k >= c_l0);
        e.wr1  = 1'(t1 % 2);
        e.ddr1 = 1'(((t1 + 1) / 2) % 2);
        e.lk1  = (k >= c_l1);
        return e;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%b expected=%b", name, edge_no, act, exp);
        end
    endtask

    // Monitor: every reference edge presents a new output sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr0",       wr0,  e.wr0);
                check("ddr0",      ddr0, e.ddr0);
                check("locked0",   lk0,  e.lk0);
                check("clk_p0",    p0,   e.ddr0);
                check("clk_n0",    n0,   ~e.ddr0);
                check("wr1",       wr1,  e.wr1);
                check("ddr1",      ddr1, e.ddr1);
                check("locked1",   lk1,  e.lk1);
                check("clk_p1",    p1,   e.ddr1);
                check("clk_n1",    n1,   ~e.ddr1);
                check("diff_pair0", n0,  ~p0);
                check("diff_pair1", n1,  ~p1);
            end
        end
    end

    int k = 0;

    task automatic step(input logic rn);
        rst_n = rn;
        @(posedge clk);
        edge_no++;
        k = rn ? k + 1 : 0;
        exp_q.push_back(model(k));
        #2;
    endtask

    initial begin
        int budget;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0);
        for (int i = 0; i < 34; i++) step(1'b1);
        step(1'b0);
        for (int i = 0; i < 230; i++) step(1'b1);
        for (int i = 0; i < 400; i++) step(($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1);

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
